// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative MULT/DIV sequencer owning the HI/LO registers (optional MULDIV_EARLY_OUT_EN)
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mf_req,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // acc holds the product upper half / the partial remainder;
  // mpl holds the multiplier (shifting out, product bits shifting in) / the quotient.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mpl_q, mpl_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             dz_q, dz_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Operand magnitudes for signed commands (MULT=0, DIV=2 have op[0]==0)
  logic             op_signed;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign op_signed = ~op[0];
  assign abs_a     = (op_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b     = (op_signed && b[WIDTH-1]) ? -b : b;

  // One shift-add multiply step on {acc, mpl}
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc_n, mul_mpl_n;

  assign mul_sum   = {1'b0, acc_q} + (mpl_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign mul_acc_n = mul_sum[WIDTH:1];
  assign mul_mpl_n = {mul_sum[0], mpl_q[WIDTH-1:1]};

  // One restoring-divide step on {rem, quot}; the shifted remainder needs one extra bit
  logic [WIDTH:0]   div_sh, div_trial;
  logic             div_ok;
  logic [WIDTH-1:0] div_acc_n, div_mpl_n;

  assign div_sh    = {acc_q, mpl_q[WIDTH-1]};
  assign div_trial = div_sh - {1'b0, mcand_q};
  assign div_ok    = ~div_trial[WIDTH];
  assign div_acc_n = div_ok ? div_trial[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign div_mpl_n = {mpl_q[WIDTH-2:0], div_ok};

`ifdef MULDIV_EARLY_OUT_EN
  // After this step cnt_q-1 multiplier bits remain unshifted in the low end of mpl
  logic [CNT_W-1:0] eo_shift;
  logic [WIDTH-1:0] eo_mask;
  logic             eo_hit;

  assign eo_shift = cnt_q - CNT_W'(1);
  assign eo_mask  = ~({WIDTH{1'b1}} << eo_shift);
  assign eo_hit   = ((mul_mpl_n & eo_mask) == '0);
`endif

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_raw = {acc_q, mpl_q};
  assign prod_fix = neg_lo_q ? -prod_raw : prod_raw;
  assign quo_fix  = neg_lo_q ? -mpl_q : mpl_q;
  assign rem_fix  = neg_hi_q ? -acc_q : acc_q;

  // Next-state, datapath step and HI/LO write selection
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mpl_d    = mpl_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      ST_IDLE: begin
        // flush beats a same-cycle start
        if (start && !flush) begin
          if (op <= 3'd3) begin
            dbz_d    = 1'b0;
            is_div_d = op[1];
            mcand_d  = abs_b;
            cnt_d    = CNT_W'(WIDTH);
            if (op[1] && (b == '0)) begin
              // Divide by zero: no iterations, FIX writes lo=all ones, hi=a untouched
              acc_d    = a;
              mpl_d    = '1;
              neg_lo_d = 1'b0;
              neg_hi_d = 1'b0;
              dz_d     = 1'b1;
              state_d  = ST_FIX;
            end else begin
              acc_d    = '0;
              mpl_d    = abs_a;
              neg_lo_d = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_hi_d = op[1] ? (op_signed & a[WIDTH-1])
                               : (op_signed & (a[WIDTH-1] ^ b[WIDTH-1]));
              dz_d     = 1'b0;
              state_d  = ST_RUN;
            end
          end else if (op == 3'd4) begin
            dbz_d = 1'b0;
            hi_d  = a;
          end else if (op == 3'd5) begin
            dbz_d = 1'b0;
            lo_d  = a;
          end
        end
      end

      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (is_div_q) begin
            acc_d = div_acc_n;
            mpl_d = div_mpl_n;
          end else begin
            acc_d = mul_acc_n;
            mpl_d = mul_mpl_n;
`ifdef MULDIV_EARLY_OUT_EN
            // Remaining steps would only shift; do them all at once
            if (eo_hit) begin
              {acc_d, mpl_d} = {mul_acc_n, mul_mpl_n} >> eo_shift;
              state_d        = ST_FIX;
            end
`endif
          end
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_FIX;
          end
        end
      end

      ST_FIX: begin
        state_d = ST_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end else begin
            lo_d = prod_fix[WIDTH-1:0];
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
          end
          if (dz_q) begin
            dbz_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, flag and HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mpl_q    <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      acc_q    <= acc_d;
      mpl_q    <= mpl_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign stall = busy & (mf_req | (start & (op <= 3'd5)));
  assign done  = done_q;
  assign dbz   = dbz_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide controller for the execute stage. Owns the HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from decode and runs a 1-bit-per-cycle shift-add or restoring-divide datapath.
- Raises a stall while a result is pending and an MFHI/MFLO or a new mul/div command arrives.
- Sits beside the ALU/shifter and feeds HI/LO to the result mux.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  command valid from decode
- op  in  3  command: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (ignored)
- a  in  WIDTH  rs operand
- b  in  WIDTH  rt operand
- mf_req  in  1  decode is issuing MFHI/MFLO this cycle
- flush  in  1  pipeline flush; abort in-flight operation
- busy  out  1  operation in progress
- stall  out  1  hold decode/execute
- done  out  1  one-cycle pulse: HI/LO updated by a mul/div
- dbz  out  1  sticky divide-by-zero flag, cleared by next accepted start
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, dbz=0, hi=0, lo=0, counter=0, internal datapath regs=0. A reset mid-operation abandons it with no HI/LO update.
- States: IDLE, RUN, FIX.
- IDLE with start=1:
  - op 0-3: latch operands, go to RUN, counter=WIDTH.
    - Signed ops latch |a| and |b|, and record the result signs: product sign = a^b; quotient sign = a^b; remainder sign = sign of a.
  - op 4/5: write hi or lo with a at the next edge; stay IDLE; no done pulse.
  - op 6/7: no effect.
- RUN:
  - One iteration per cycle; counter decrements.
  - Multiply: add the multiplicand to the accumulator when the current multiplier LSB is 1, then shift right. The 2*WIDTH product builds in {acc, mplier}.
  - Divide: restoring divide. Shift {rem, quot} left, trial-subtract the divisor; if the remainder is non-negative, commit it and set quot LSB=1.
  - When counter reaches 1, go to FIX at the next edge.
- FIX:
  - Apply sign correction with two's-complement negate.
  - Write HI/LO: mult gives hi=upper, lo=lower; div gives lo=quotient, hi=remainder.
  - Pulse done=1 for the cycle after this edge; return to IDLE.
- Latency: start accepted at edge 0, then WIDTH RUN edges plus 1 FIX edge. HI/LO are valid and done=1 in the cycle after edge WIDTH+1 (cycle 33 for WIDTH=32).
- Divide by zero (b==0, op 2/3): skip RUN and go straight to FIX. Result: lo={WIDTH{1}}, hi=a unmodified; dbz=1; done pulses after 2 edges.
- Signed overflow case (DIV most-negative / -1): lo=most-negative, hi=0. There is no exception.
- busy=1 in RUN and FIX.
- stall = busy & (mf_req | (start & op<=5)). Commands arriving while busy are not accepted; decode holds them.
- MTHI/MTLO while busy: stalled, never lost.
- flush=1 in RUN or FIX: go to IDLE at the next edge with no HI/LO write, no done pulse, dbz unchanged. flush in IDLE has no effect.
- flush and start in the same IDLE cycle: flush wins, start is ignored.
- HI/LO are readable only when not busy. mf_req in the same cycle as done sees the new values and is not stalled.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - In RUN for op 0/1, if the remaining unshifted multiplier bits are all zero, shift the accumulator into position in one step and go to FIX at the next edge.
  - Results are bit-identical to the full-length run; latency varies from 2 to WIDTH+1 edges.
  - Divide is unchanged.
- Undefined: fixed latency as above.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0x2 → done after 33 edges, hi=0x00000001, lo=0xFFFFFFFE; busy=1 throughout; stall=1 when mf_req is asserted mid-run.
- MULT a=0xFFFFFFFD(-3), b=0x00000007 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=-7, b=2 → lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
- DIVU a=100, b=0 → done after 2 edges, lo=0xFFFFFFFF, hi=100, dbz=1. The next DIVU 100/7 clears dbz and gives lo=14, hi=2.
- MULTU 5*5 then flush at cycle 10 → busy=0 at the next cycle, hi/lo keep prior values, no done pulse. rst_n pulse mid-run → hi=lo=0 immediately.
- MTHI a=0xDEADBEEF in IDLE → hi=0xDEADBEEF next cycle, done=0. MTLO issued while busy → stall=1 until FIX completes, then applied.
- With MULDIV_EARLY_OUT_EN defined: MULTU 3*5 → lo=15, hi=0, done within 4 edges. Without the macro → done at edge 33 with identical values.
